// File: rtl/program_loader.sv
// Boot-time program loader: receives a little-endian word count followed by that many
// little-endian instruction words, writes them to instruction memory, then releases the CPU.
module program_loader #(
    parameter logic [63:0] BASE_ADDRESS = 64'h0,
    parameter int unsigned MAX_WORDS    = 256
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        byte_valid,
    input  logic [7:0]  byte_data,
    output logic        byte_ready,
    output logic        im_write_enable,
    output logic [63:0] im_write_address,
    output logic [31:0] im_write_data,
    output logic        cpu_reset,
    output logic        done,
    output logic        error
);

    typedef enum logic [1:0] {RX_COUNT, RX_WORD, DONE, ERROR} state_t;

    state_t      state_q;
    logic [1:0]  byte_cnt_q;
    logic [31:0] word_q;
    logic [31:0] word_d;
    logic [31:0] count_q;
    logic [31:0] word_idx_q;
    logic        we_q;
    logic [63:0] addr_q;
    logic [31:0] data_q;
    logic        cpu_rst_q;
    logic        done_q;
    logic        error_q;
    logic        xfer;

    // Ready is forced low while reset is asserted so no byte can slip in that cycle.
    assign byte_ready = !reset && (state_q == RX_COUNT || state_q == RX_WORD);
    assign xfer       = byte_valid && byte_ready;

    always_comb begin
        word_d = word_q;
        word_d[8*byte_cnt_q +: 8] = byte_data;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= RX_COUNT;
            byte_cnt_q <= 2'd0;
            word_q     <= 32'd0;
            count_q    <= 32'd0;
            word_idx_q <= 32'd0;
            we_q       <= 1'b0;
            addr_q     <= BASE_ADDRESS;
            data_q     <= 32'd0;
            cpu_rst_q  <= 1'b1;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
        end else begin
            we_q      <= 1'b0;
            // Release the CPU one cycle after DONE is entered, once the last write has landed.
            cpu_rst_q <= (state_q != DONE);
            if (xfer) begin
                byte_cnt_q <= byte_cnt_q + 2'd1;
                word_q     <= word_d;
                if (byte_cnt_q == 2'd3) begin
                    word_q <= 32'd0;
                    case (state_q)
                        RX_COUNT: begin
                            count_q    <= word_d;
                            word_idx_q <= 32'd0;
                            if (word_d == 32'd0) begin
                                state_q <= DONE;
                                done_q  <= 1'b1;
                            end else if (word_d > MAX_WORDS) begin
                                state_q <= ERROR;
                                error_q <= 1'b1;
                            end else begin
                                state_q <= RX_WORD;
                            end
                        end
                        RX_WORD: begin
                            we_q       <= 1'b1;
                            data_q     <= word_d;
                            addr_q     <= BASE_ADDRESS + {30'd0, word_idx_q, 2'b00};
                            word_idx_q <= word_idx_q + 32'd1;
                            if (word_idx_q + 32'd1 == count_q) begin
                                state_q <= DONE;
                                done_q  <= 1'b1;
                            end
                        end
                        default: state_q <= state_q;
                    endcase
                end
            end
        end
    end

    assign im_write_enable  = we_q;
    assign im_write_address = addr_q;
    assign im_write_data    = data_q;
    assign cpu_reset        = cpu_rst_q;
    assign done             = done_q;
    assign error            = error_q;

endmodule

// File: tb/tb_program_loader.sv
// Directed bench for program_loader: cycle-by-cycle vector table plus hand sequences
// for stalled streams, a non-zero base address and the MAX_WORDS boundary.
module tb_program_loader;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic        rst1, vld1, rdy1, we1, cr1, dn1, er1;
    logic [7:0]  d1;
    logic [63:0] ad1;
    logic [31:0] dt1;
    logic        rst2, vld2, rdy2, we2, cr2, dn2, er2;
    logic [7:0]  d2;
    logic [63:0] ad2;
    logic [31:0] dt2;

    program_loader u_dut1 (
        .clock(clock), .reset(rst1), .byte_valid(vld1), .byte_data(d1), .byte_ready(rdy1),
        .im_write_enable(we1), .im_write_address(ad1), .im_write_data(dt1),
        .cpu_reset(cr1), .done(dn1), .error(er1)
    );

    program_loader #(.BASE_ADDRESS(64'h1000), .MAX_WORDS(3)) u_dut2 (
        .clock(clock), .reset(rst2), .byte_valid(vld2), .byte_data(d2), .byte_ready(rdy2),
        .im_write_enable(we2), .im_write_address(ad2), .im_write_data(dt2),
        .cpu_reset(cr2), .done(dn2), .error(er2)
    );

    typedef struct {
        logic         rst;
        logic         vld;
        logic [7:0]   d;
        logic [100:0] exp;   // {ready, we, addr, data, done, cpu_reset, error}
    } vec_t;

    vec_t        vt[$];
    logic [63:0] wa1[$], wa2[$];
    logic [31:0] wd1[$], wd2[$];
    int          n_vec  = 0;
    int          n_miss = 0;

    task automatic add(input logic rst, input logic vld, input logic [7:0] d, input logic rdy,
                       input logic we, input logic [63:0] a, input logic [31:0] dat,
                       input logic dn, input logic cpr, input logic er);
        vec_t v;
        v.rst = rst; v.vld = vld; v.d = d;
        v.exp = {rdy, we, a, dat, dn, cpr, er};
        vt.push_back(v);
    endtask

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
        if (we1 === 1'b1) begin wa1.push_back(ad1); wd1.push_back(dt1); end
        if (we2 === 1'b1) begin wa2.push_back(ad2); wd2.push_back(dt2); end
    endtask

    task automatic feed1(input logic rst, input logic vld, input logic [7:0] d);
        rst1 = rst; vld1 = vld; d1 = d;
        tick();
    endtask

    task automatic feed2(input logic rst, input logic vld, input logic [7:0] d);
        rst2 = rst; vld2 = vld; d2 = d;
        tick();
    endtask

    logic [7:0]  sb[12];
    logic [31:0] w2[3];
    logic        r;

    initial begin
        rst1 = 1'b1; vld1 = 1'b0; d1 = 8'h00;
        rst2 = 1'b1; vld2 = 1'b0; d2 = 8'h00;

        // Two-word stream, valid every cycle.
        add(1,0,8'h00, 0, 0,64'h0,32'h0,        0,1,0);
        add(0,1,8'h02, 1, 0,64'h0,32'h0,        0,1,0);
        add(0,1,8'h00, 1, 0,64'h0,32'h0,        0,1,0);
        add(0,1,8'h00, 1, 0,64'h0,32'h0,        0,1,0);
        add(0,1,8'h00, 1, 0,64'h0,32'h0,        0,1,0);
        add(0,1,8'h13, 1, 0,64'h0,32'h0,        0,1,0);
        add(0,1,8'h05, 1, 0,64'h0,32'h0,        0,1,0);
        add(0,1,8'h10, 1, 0,64'h0,32'h0,        0,1,0);
        add(0,1,8'h00, 1, 1,64'h0,32'h00100513, 0,1,0);
        add(0,1,8'h93, 1, 0,64'h0,32'h00100513, 0,1,0);
        add(0,1,8'h05, 1, 0,64'h0,32'h00100513, 0,1,0);
        add(0,1,8'h20, 1, 0,64'h0,32'h00100513, 0,1,0);
        add(0,1,8'h00, 1, 1,64'h4,32'h00200593, 1,1,0);
        add(0,1,8'hFF, 0, 0,64'h4,32'h00200593, 1,0,0);
        add(0,0,8'h00, 0, 0,64'h4,32'h00200593, 1,0,0);
        // Zero count: straight to DONE, later bytes ignored.
        add(1,0,8'h00, 0, 0,64'h0,32'h0,        0,1,0);
        add(0,1,8'h00, 1, 0,64'h0,32'h0,        0,1,0);
        add(0,1,8'h00, 1, 0,64'h0,32'h0,        0,1,0);
        add(0,1,8'h00, 1, 0,64'h0,32'h0,        0,1,0);
        add(0,1,8'h00, 1, 0,64'h0,32'h0,        1,1,0);
        add(0,1,8'h55, 0, 0,64'h0,32'h0,        1,0,0);
        add(0,1,8'h66, 0, 0,64'h0,32'h0,        1,0,0);
        // Count 257 exceeds MAX_WORDS: ERROR, CPU held, no writes.
        add(1,0,8'h00, 0, 0,64'h0,32'h0,        0,1,0);
        add(0,1,8'h01, 1, 0,64'h0,32'h0,        0,1,0);
        add(0,1,8'h01, 1, 0,64'h0,32'h0,        0,1,0);
        add(0,1,8'h00, 1, 0,64'h0,32'h0,        0,1,0);
        add(0,1,8'h00, 1, 0,64'h0,32'h0,        0,1,1);
        add(0,1,8'h13, 0, 0,64'h0,32'h0,        0,1,1);
        add(0,1,8'h00, 0, 0,64'h0,32'h0,        0,1,1);
        // Reset mid-word, then reset on a word's final byte, then a clean 1-word stream.
        add(1,0,8'h00, 0, 0,64'h0,32'h0,        0,1,0);
        add(0,1,8'h01, 1, 0,64'h0,32'h0,        0,1,0);
        add(0,1,8'h00, 1, 0,64'h0,32'h0,        0,1,0);
        add(0,1,8'h00, 1, 0,64'h0,32'h0,        0,1,0);
        add(0,1,8'h00, 1, 0,64'h0,32'h0,        0,1,0);
        add(0,1,8'hAA, 1, 0,64'h0,32'h0,        0,1,0);
        add(0,1,8'hBB, 1, 0,64'h0,32'h0,        0,1,0);
        add(1,1,8'hCC, 0, 0,64'h0,32'h0,        0,1,0);
        add(0,1,8'h01, 1, 0,64'h0,32'h0,        0,1,0);
        add(0,1,8'h00, 1, 0,64'h0,32'h0,        0,1,0);
        add(0,1,8'h00, 1, 0,64'h0,32'h0,        0,1,0);
        add(0,1,8'h00, 1, 0,64'h0,32'h0,        0,1,0);
        add(0,1,8'h78, 1, 0,64'h0,32'h0,        0,1,0);
        add(0,1,8'h56, 1, 0,64'h0,32'h0,        0,1,0);
        add(0,1,8'h34, 1, 0,64'h0,32'h0,        0,1,0);
        add(1,1,8'h12, 0, 0,64'h0,32'h0,        0,1,0);
        add(0,1,8'h01, 1, 0,64'h0,32'h0,        0,1,0);
        add(0,1,8'h00, 1, 0,64'h0,32'h0,        0,1,0);
        add(0,1,8'h00, 1, 0,64'h0,32'h0,        0,1,0);
        add(0,1,8'h00, 1, 0,64'h0,32'h0,        0,1,0);
        add(0,1,8'h78, 1, 0,64'h0,32'h0,        0,1,0);
        add(0,1,8'h56, 1, 0,64'h0,32'h0,        0,1,0);
        add(0,1,8'h34, 1, 0,64'h0,32'h0,        0,1,0);
        add(0,1,8'h12, 1, 1,64'h0,32'h12345678, 1,1,0);
        add(0,0,8'h00, 0, 0,64'h0,32'h12345678, 1,0,0);

        for (int i = 0; i < vt.size(); i++) begin
            rst1 = vt[i].rst; vld1 = vt[i].vld; d1 = vt[i].d;
            #1;
            r = rdy1;
            tick();
            chk($sformatf("vec%0d", i), {27'd0, r, we1, ad1, dt1, dn1, cr1, er1},
                {27'd0, vt[i].exp});
        end

        // Same two-word stream with an idle cycle (junk data) before every byte.
        sb = '{8'h02, 8'h00, 8'h00, 8'h00, 8'h13, 8'h05, 8'h10, 8'h00,
               8'h93, 8'h05, 8'h20, 8'h00};
        feed1(1, 0, 8'h00);
        wa1.delete(); wd1.delete();
        for (int i = 0; i < 12; i++) begin
            feed1(0, 0, 8'hEE);
            feed1(0, 1, sb[i]);
        end
        chk("stall_done", {127'd0, dn1}, 128'd1);
        feed1(0, 0, 8'h00);
        chk("stall_cpu_rst", {127'd0, cr1}, 128'd0);
        feed1(0, 1, 8'h00);
        feed1(0, 1, 8'h00);
        chk("stall_nwrites", 128'(wa1.size()), 128'd2);
        chk("stall_w0", {32'd0, (wa1.size() > 0) ? wa1[0] : '1, (wd1.size() > 0) ? wd1[0] : '1},
            {32'd0, 64'h0, 32'h00100513});
        chk("stall_w1", {32'd0, (wa1.size() > 1) ? wa1[1] : '1, (wd1.size() > 1) ? wd1[1] : '1},
            {32'd0, 64'h4, 32'h00200593});

        // Base 0x1000 with N equal to MAX_WORDS (3): accepted, three sequential addresses.
        w2 = '{32'h04030201, 32'h08070605, 32'h0C0B0A09};
        feed2(1, 0, 8'h00);
        wa2.delete(); wd2.delete();
        feed2(0, 1, 8'h03); feed2(0, 1, 8'h00); feed2(0, 1, 8'h00); feed2(0, 1, 8'h00);
        for (int i = 0; i < 3; i++)
            for (int k = 0; k < 4; k++)
                feed2(0, 1, w2[i][8*k +: 8]);
        feed2(0, 0, 8'h00);
        chk("base_nwrites", 128'(wa2.size()), 128'd3);
        for (int i = 0; i < 3; i++)
            chk($sformatf("base_w%0d", i),
                {32'd0, (wa2.size() > i) ? wa2[i] : '1, (wd2.size() > i) ? wd2[i] : '1},
                {32'd0, 64'h1000 + 64'(4 * i), w2[i]});
        chk("base_status", {125'd0, dn2, er2, cr2}, {125'd0, 3'b100});

        // N = MAX_WORDS + 1 on the same instance: rejected.
        feed2(1, 0, 8'h00);
        wa2.delete(); wd2.delete();
        feed2(0, 1, 8'h04); feed2(0, 1, 8'h00); feed2(0, 1, 8'h00); feed2(0, 1, 8'h00);
        feed2(0, 1, 8'h11); feed2(0, 1, 8'h22); feed2(0, 1, 8'h33); feed2(0, 1, 8'h44);
        feed2(0, 0, 8'h00);
        chk("max_plus1_status", {124'd0, rdy2, dn2, er2, cr2}, {124'd0, 4'b0011});
        chk("max_plus1_nwrites", 128'(wa2.size()), 128'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
